// File: rtl/cv32e40x_clock_gate_ctrl.sv
// Sequences the core clock-gate enable: idle counting, sleep handshake, gating and timed wake.
// Runs only on the free-running clock; all outputs are registered decodes of the next state.
module cv32e40x_clock_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cg_enable_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               busy_i,
    input  logic               wake_i,
    output logic               sleep_req_o,
    input  logic               sleep_ack_i,
    output logic               clk_en_o,
    output logic               clk_rdy_o,
    output logic               gated_o
);

    localparam int ICW = $clog2(IDLE_CYCLES + 1);
    localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYCLES - 1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYCLES);
    localparam logic [WCW-1:0] WAKE_LAST = WCW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GATED, S_WAKE} state_t;

    state_t         r_state, w_state_nxt;
    logic [ICW-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic [WCW-1:0] r_wake_cnt, w_wake_cnt_nxt;
    logic           w_idle, w_wake_evt;
    logic           w_en, w_rdy, w_sreq, w_gated;

    assign w_idle     = cg_enable_i & ~|req_i & ~busy_i & ~wake_i;
    // Losing gating permission while gated is handled like any other wake request.
    assign w_wake_evt = |req_i | wake_i | ~cg_enable_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_wake_cnt_nxt = r_wake_cnt;
        case (r_state)
            S_RUN: begin
                if (!w_idle) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_state_nxt    = S_DRAIN;
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt != IDLE_MAX) begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // Any activity beats a simultaneous acknowledge.
                if (!w_idle) begin
                    w_state_nxt    = S_RUN;
                    w_idle_cnt_nxt = '0;
                end else if (sleep_ack_i) begin
                    w_state_nxt = S_GATED;
                end
            end
            S_GATED: begin
                if (w_wake_evt) begin
                    w_state_nxt    = (WAKE_CYCLES == 0) ? S_RUN : S_WAKE;
                    w_wake_cnt_nxt = '0;
                    w_idle_cnt_nxt = '0;
                end
            end
            S_WAKE: begin
                if (r_wake_cnt == WAKE_LAST) begin
                    w_state_nxt    = S_RUN;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_idle_cnt_nxt = '0;
                w_wake_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_en    = 1'b1;
        w_rdy   = 1'b1;
        w_sreq  = 1'b0;
        w_gated = 1'b0;
        case (w_state_nxt)
            S_DRAIN: w_sreq = 1'b1;
            S_GATED: begin
                w_en    = 1'b0;
                w_rdy   = 1'b0;
                w_gated = 1'b1;
            end
            S_WAKE:  w_rdy = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_RUN;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
            clk_en_o    <= 1'b1;
            clk_rdy_o   <= 1'b1;
            sleep_req_o <= 1'b0;
            gated_o     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_wake_cnt  <= w_wake_cnt_nxt;
            clk_en_o    <= w_en;
            clk_rdy_o   <= w_rdy;
            sleep_req_o <= w_sreq;
            gated_o     <= w_gated;
        end
    end

endmodule

// File: tb/tb_cv32e40x_clock_gate_ctrl.sv
// Directed bench: stimulus schedules expected outputs {en,rdy,sleep_req,gated} for future cycles;
// per-cycle monitors pop and compare, and check the gating invariants on both instances.
module tb_cv32e40x_clock_gate_ctrl;

    localparam logic [3:0] RUN   = 4'b1100;
    localparam logic [3:0] DRAIN = 4'b1110;
    localparam logic [3:0] GATED = 4'b0001;
    localparam logic [3:0] WAKE  = 4'b1000;

    typedef struct {
        int         cyc;
        string      nm;
        logic [3:0] v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // main instance: default parameters
    logic       rst = 1'b1, cg = 1'b1, busy = 1'b0, wake = 1'b0, ack = 1'b0;
    logic [3:0] req = '0;
    logic       sreq, en, rdy, gtd;

    cv32e40x_clock_gate_ctrl #(.NUM_REQ(4), .IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .cg_enable_i(cg), .req_i(req), .busy_i(busy),
        .wake_i(wake), .sleep_req_o(sreq), .sleep_ack_i(ack), .clk_en_o(en),
        .clk_rdy_o(rdy), .gated_o(gtd));

    // second instance: immediate wake, short idle window
    logic       z_rst = 1'b1, z_cg = 1'b1, z_busy = 1'b0, z_wake = 1'b0, z_ack = 1'b0;
    logic [3:0] z_req = '0;
    logic       z_sreq, z_en, z_rdy, z_gtd;

    cv32e40x_clock_gate_ctrl #(.NUM_REQ(4), .IDLE_CYCLES(4), .WAKE_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(z_rst), .cg_enable_i(z_cg), .req_i(z_req), .busy_i(z_busy),
        .wake_i(z_wake), .sleep_req_o(z_sreq), .sleep_ack_i(z_ack), .clk_en_o(z_en),
        .clk_rdy_o(z_rdy), .gated_o(z_gtd));

    exp_t q1[$];
    exp_t q0[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp1(input int d, input string nm, input logic [3:0] v);
        q1.push_back('{cyc + d, nm, v});
    endtask

    task automatic exp0(input int d, input string nm, input logic [3:0] v);
        q0.push_back('{cyc + d, nm, v});
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b want %b (en,rdy,sreq,gated)", nm, cyc, act, want);
        end
    endtask

    task automatic inv(input string nm, input logic ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s @cyc %0d: invariant violated", nm, cyc);
        end
    endtask

    logic p_gtd = 1'b0, p_sreq = 1'b0, z_p_gtd = 1'b0, z_p_sreq = 1'b0;

    always @(negedge clk) begin
        for (int i = q1.size() - 1; i >= 0; i--) begin
            if (q1[i].cyc == cyc) begin
                chk(q1[i].nm, {en, rdy, sreq, gtd}, q1[i].v);
                q1.delete(i);
            end
        end
        if (!rst) begin
            inv("inv_en0", en || (gtd && !rdy));
            inv("inv_sreq_en", !sreq || en);
            inv("inv_gated_from_drain", !(gtd && !p_gtd) || p_sreq);
        end
        p_gtd  = gtd;
        p_sreq = sreq;
    end

    always @(negedge clk) begin
        for (int i = q0.size() - 1; i >= 0; i--) begin
            if (q0[i].cyc == cyc) begin
                chk(q0[i].nm, {z_en, z_rdy, z_sreq, z_gtd}, q0[i].v);
                q0.delete(i);
            end
        end
        if (!z_rst) begin
            inv("z_inv_en0", z_en || (z_gtd && !z_rdy));
            inv("z_inv_sreq_en", !z_sreq || z_en);
            inv("z_inv_gated_from_drain", !(z_gtd && !z_p_gtd) || z_p_sreq);
        end
        z_p_gtd  = z_gtd;
        z_p_sreq = z_sreq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, idle count to DRAIN, ack -> GATED one cycle later
        step(1);
        exp1(0, "reset", RUN);
        rst = 1'b0;
        exp1(15, "t1_run_at_15", RUN);
        exp1(16, "t1_drain_at_16", DRAIN);
        step(16);
        exp1(1, "t1_drain_hold", DRAIN);
        step(1);
        ack = 1'b1;
        exp1(0, "t1_ack_same_cycle", DRAIN);
        exp1(1, "t1_gated", GATED);
        step(1);
        ack  = 1'b0;
        busy = 1'b1;                         // busy must not wake a gated domain
        exp1(1, "t1_busy_ignored", GATED);
        step(1);

        // 4: one-cycle wake pulse, WAKE_CYCLES=2
        busy = 1'b0;
        wake = 1'b1;
        exp1(1, "t4_en_back", WAKE);
        step(1);
        wake = 1'b0;
        exp1(1, "t4_still_settling", WAKE);
        exp1(2, "t4_rdy", RUN);
        step(2);

        // 2: idle run broken by req[2] at idle_cnt=10
        step(10);
        req[2] = 1'b1;
        exp1(1, "t2_pulse", RUN);
        step(1);
        req = '0;
        exp1(15, "t2_not_before", RUN);
        exp1(16, "t2_drain", DRAIN);
        step(16);

        // 3: request and ack together in DRAIN -> RUN
        req[0] = 1'b1;
        ack    = 1'b1;
        exp1(1, "t3_abort", RUN);
        step(1);
        req = '0;
        ack = 1'b0;
        exp1(1, "t3_after", RUN);
        step(1);

        // 6a: reset while GATED
        exp1(16, "t6_drain_a", DRAIN);
        step(16);
        ack = 1'b1;
        exp1(1, "t6_gated_a", GATED);
        step(1);
        ack = 1'b0;
        rst = 1'b1;
        exp1(1, "t6_rst_gated", RUN);
        step(1);
        rst = 1'b0;

        // 6b: reset while WAKE
        exp1(16, "t6_drain_b", DRAIN);
        step(16);
        ack = 1'b1;
        exp1(1, "t6_gated_b", GATED);
        step(1);
        ack  = 1'b0;
        wake = 1'b1;
        exp1(1, "t6_wake", WAKE);
        step(1);
        wake = 1'b0;
        rst  = 1'b1;
        exp1(1, "t6_rst_wake", RUN);
        step(1);
        rst = 1'b0;

        // cg_enable dropping while gated wakes the domain
        exp1(16, "cg_drain", DRAIN);
        step(16);
        ack = 1'b1;
        exp1(1, "cg_gated", GATED);
        step(1);
        ack = 1'b0;
        cg  = 1'b0;
        exp1(1, "cg_drop_wake", WAKE);
        exp1(3, "cg_drop_rdy", RUN);
        step(3);

        // 6c: gating disabled for 100 idle cycles never requests sleep
        exp1(20, "t6_nogate_20", RUN);
        exp1(60, "t6_nogate_60", RUN);
        exp1(100, "t6_nogate_100", RUN);
        step(100);

        // 5: WAKE_CYCLES=0 -> en and rdy return together
        exp0(0, "t5_reset", RUN);
        z_rst = 1'b0;
        exp0(3, "t5_run_at_3", RUN);
        exp0(4, "t5_drain", DRAIN);
        step(4);
        z_ack = 1'b1;
        exp0(1, "t5_gated", GATED);
        step(1);
        z_ack  = 1'b0;
        z_req[3] = 1'b1;
        exp0(1, "t5_en_rdy_together", RUN);
        step(1);
        z_req = '0;
        step(2);

        n_cmp++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations: got %0d/%0d left want 0", q1.size(), q0.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
